test_status_reporter: RTL



---
 rtl/test_status_reporter.sv | 103 ++++++++++
 1 files changed

// File: rtl/test_status_reporter.sv
// test_status_reporter: Wishbone status slave that turns firmware test results into
// a stable success level plus a next_test strobe, with count/all_pass/overrun readback.
module test_status_reporter #(
    parameter int SETUP_CYCLES  = 4,
    parameter int DEFAULT_PULSE = 16,
    parameter int HOLD_CYCLES   = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [3:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o,
    output logic        success_out,
    output logic        next_test_out,
    output logic [1:0]  status_oeb
);
    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;
    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d, pw_q, pw_d, count_q, count_d;
    logic        ack_q, ack_d, success_q, success_d, next_q, next_d;
    logic        all_pass_q, all_pass_d, overrun_q, overrun_d;
    logic [31:0] dat_q, dat_d;
    logic [1:0]  a;
    logic        req, wr, report, accept, done, busy, clr_cnt, clr_ov;

    assign a       = wb_adr_i[3:2];
    assign req     = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr      = req & wb_we_i & wb_sel_i[0];
    assign report  = wr && a == 2'd0;
    assign busy    = state_q != IDLE;
    assign accept  = report && !busy;
    assign done    = cnt_q == 8'd0;
    assign clr_cnt = wr && a == 2'd2 && wb_dat_i[0];
    assign clr_ov  = wr && a == 2'd2 && wb_dat_i[2];

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            pw_q       <= 8'(DEFAULT_PULSE);
            count_q    <= 8'd0;
            ack_q      <= 1'b0;
            success_q  <= 1'b0;
            next_q     <= 1'b0;
            all_pass_q <= 1'b1;
            overrun_q  <= 1'b0;
            dat_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pw_q       <= pw_d;
            count_q    <= count_d;
            ack_q      <= ack_d;
            success_q  <= success_d;
            next_q     <= next_d;
            all_pass_q <= all_pass_d;
            overrun_q  <= overrun_d;
            dat_q      <= dat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? SETUP : IDLE;
            SETUP:   state_d = done ? PULSE : SETUP;
            PULSE:   state_d = done ? HOLD : PULSE;
            default: state_d = done ? IDLE : HOLD;
        endcase
    end

    always_comb begin
        cnt_d = busy ? cnt_q - 8'd1 : cnt_q;
        if (accept)
            cnt_d = 8'(SETUP_CYCLES - 1);
        else if (state_q == SETUP && done)
            cnt_d = pw_q - 8'd1;
        else if (state_q == PULSE && done)
            cnt_d = 8'(HOLD_CYCLES - 1);
        next_d     = (state_q == SETUP && done) ? 1'b1 : (state_q == PULSE && done) ? 1'b0 : next_q;
        success_d  = accept ? wb_dat_i[0] : success_q;
        count_d    = clr_cnt ? 8'd0 : (accept && count_q != 8'hff) ? count_q + 8'd1 : count_q;
        all_pass_d = clr_cnt ? 1'b1 : accept ? all_pass_q & wb_dat_i[0] : all_pass_q;
        overrun_d  = (report && busy) ? 1'b1 : clr_ov ? 1'b0 : overrun_q;
        // A zero pulse width would never let the PULSE counter expire cleanly
        pw_d       = (wr && a == 2'd1) ? ((wb_dat_i[7:0] == 8'd0) ? 8'd1 : wb_dat_i[7:0]) : pw_q;
        ack_d      = req;
        dat_d      = (req && !wb_we_i) ?
                     ((a == 2'd0) ? {16'd0, count_q, 5'd0, overrun_q, busy, all_pass_q} :
                      (a == 2'd1) ? {24'd0, pw_q} : 32'd0) : 32'd0;
    end

    assign wb_ack_o      = ack_q;
    assign wb_dat_o      = dat_q;
    assign success_out   = success_q;
    assign next_test_out = next_q;
    assign status_oeb    = 2'b00;
endmodule
